hyperbus_arbiter: RTL



---
 rtl/hyperbus_arbiter_if.sv | 47 ++++
 rtl/hyperbus_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/hyperbus_arbiter_if.sv
// Bundles both request ports and the HyperBus controller-side lines of the arbiter.
// slave is the arbiter's view; master is the view of the ports and controller around it.
interface hyperbus_arbiter_if #(
    parameter int WIDTH       = 8,
    parameter int MASK_W      = ((WIDTH << 1) / 8) + 1,
    parameter int ADDR_LENGTH = 32,
    parameter int LEN_WIDTH   = 8
);
    logic                   p0_req, p1_req;
    logic                   p0_we, p1_we;
    logic                   p0_reg_space, p1_reg_space;
    logic [ADDR_LENGTH-1:0] p0_adr, p1_adr;
    logic [LEN_WIDTH-1:0]   p0_len, p1_len;
    logic [2*WIDTH-1:0]     p0_wdat, p1_wdat;
    logic [MASK_W-1:0]      p0_mask, p1_mask;
    logic                   p0_gnt, p1_gnt;
    logic                   p0_wready, p1_wready;
    logic                   p0_rvalid, p1_rvalid;
    logic [2*WIDTH-1:0]     p0_rdat, p1_rdat;
    logic                   p0_done, p1_done;
    logic                   p0_err, p1_err;

    logic                   hb_wrq, hb_rrq, hb_reg_space;
    logic [ADDR_LENGTH-1:0] hb_adr;
    logic [2*WIDTH-1:0]     hb_dat;
    logic [MASK_W-1:0]      hb_mask;
    logic                   hb_ready, hb_valid;
    logic [2*WIDTH-1:0]     hb_dat_i;

    modport slave (
        input  p0_req, p0_we, p0_reg_space, p0_adr, p0_len, p0_wdat, p0_mask,
        input  p1_req, p1_we, p1_reg_space, p1_adr, p1_len, p1_wdat, p1_mask,
        output p0_gnt, p0_wready, p0_rvalid, p0_rdat, p0_done, p0_err,
        output p1_gnt, p1_wready, p1_rvalid, p1_rdat, p1_done, p1_err,
        output hb_wrq, hb_rrq, hb_reg_space, hb_adr, hb_dat, hb_mask,
        input  hb_ready, hb_valid, hb_dat_i
    );

    modport master (
        output p0_req, p0_we, p0_reg_space, p0_adr, p0_len, p0_wdat, p0_mask,
        output p1_req, p1_we, p1_reg_space, p1_adr, p1_len, p1_wdat, p1_mask,
        input  p0_gnt, p0_wready, p0_rvalid, p0_rdat, p0_done, p0_err,
        input  p1_gnt, p1_wready, p1_rvalid, p1_rdat, p1_done, p1_err,
        input  hb_wrq, hb_rrq, hb_reg_space, hb_adr, hb_dat, hb_mask,
        output hb_ready, hb_valid, hb_dat_i
    );
endinterface

// File: rtl/hyperbus_arbiter.sv
// Two-port round-robin arbiter and burst sequencer in front of the hyperbus controller.
// Counts words per burst, enforces an idle gap between bursts and a stall timeout.
module hyperbus_arbiter #(
    parameter int WIDTH       = 8,
    parameter int MASK_W      = ((WIDTH << 1) / 8) + 1,
    parameter int ADDR_LENGTH = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int GAP_COUNT   = 3,
    parameter int TIMEOUT     = 64
) (
    input logic               clk90,
    input logic               rst,
    hyperbus_arbiter_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] XFER = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] GAP  = 3'd4;

    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W   = $clog2(GAP_COUNT + 1);

    logic [2:0]             state;
    logic                   ptr;
    logic                   owner;
    logic                   we_q;
    logic                   reg_q;
    logic                   err_q;
    logic [ADDR_LENGTH-1:0] adr_q;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [STALL_W-1:0]     stall_cnt;
    logic [GAP_W-1:0]       gap_cnt;

    logic [1:0]             req;
    logic                   pick;
    logic                   busy;
    logic                   xfer;
    logic                   live;
    logic                   word;
    logic                   sel0, sel1;
    logic [2*WIDTH-1:0]     wdat_sel;
    logic [MASK_W-1:0]      mask_sel;

    assign req  = {bus.p1_req, bus.p0_req};
    // The pointer port wins a tie; otherwise whichever port is requesting.
    assign pick = req[ptr] ? ptr : ~ptr;
    assign busy = (state == LOAD) || (state == XFER) || (state == DONE);
    assign xfer = (state == XFER);
    assign live = xfer && (remaining != '0);
    assign word = live && (we_q ? bus.hb_ready : bus.hb_valid);
    assign sel0 = busy && !owner;
    assign sel1 = busy && owner;

    // NOTE: every register below is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            we_q      <= 1'b0;
            reg_q     <= 1'b0;
            err_q     <= 1'b0;
            adr_q     <= '0;
            remaining <= '0;
            stall_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner     <= pick;
                        we_q      <= pick ? bus.p1_we        : bus.p0_we;
                        reg_q     <= pick ? bus.p1_reg_space : bus.p0_reg_space;
                        adr_q     <= pick ? bus.p1_adr       : bus.p0_adr;
                        remaining <= pick ? bus.p1_len       : bus.p0_len;
                        err_q     <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (remaining == '0) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        stall_cnt <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (remaining == '0) begin
                        state <= DONE;
                    end else if (word) begin
                        remaining <= remaining - 1'b1;
                        stall_cnt <= '0;
                    end else if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
                        // Stall limit reached: abandon the rest of the burst.
                        stall_cnt <= STALL_W'(TIMEOUT);
                        remaining <= '0;
                        err_q     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                DONE: begin
                    ptr     <= ~ptr;
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_COUNT - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wdat_sel = owner ? bus.p1_wdat : bus.p0_wdat;
    assign mask_sel = owner ? bus.p1_mask : bus.p0_mask;

    // Controller lines are decoded from registered state so reset clears them at once.
    assign bus.hb_wrq       = live && we_q;
    assign bus.hb_rrq       = live && !we_q;
    assign bus.hb_reg_space = xfer && reg_q;
    assign bus.hb_adr       = xfer ? adr_q : '0;
    assign bus.hb_dat       = xfer ? wdat_sel : '0;
    assign bus.hb_mask      = xfer ? mask_sel : '0;

    assign bus.p0_gnt    = sel0;
    assign bus.p1_gnt    = sel1;
    assign bus.p0_wready = sel0 && word && we_q;
    assign bus.p1_wready = sel1 && word && we_q;
    assign bus.p0_rvalid = sel0 && word && !we_q;
    assign bus.p1_rvalid = sel1 && word && !we_q;
    assign bus.p0_rdat   = bus.p0_rvalid ? bus.hb_dat_i : '0;
    assign bus.p1_rdat   = bus.p1_rvalid ? bus.hb_dat_i : '0;
    assign bus.p0_done   = sel0 && (state == DONE);
    assign bus.p1_done   = sel1 && (state == DONE);
    assign bus.p0_err    = bus.p0_done && err_q;
    assign bus.p1_err    = bus.p1_done && err_q;
endmodule
